// File: rtl/layer_seq_pkg.sv
// Shared state encoding and default sizing for the layer sequencer and the forward datapath.
// Pure declarations: no logic, no latency, no flow control.
package layer_seq_pkg;

  localparam int LAYER_MAX_DEF      = 3;
  localparam int NUM_NEURON_DEF     = 5;
  localparam int INPUT_SIZE_DEF     = 9;
  localparam int WEIGHT_SIZE_DEF    = 17;
  localparam int ADDR_SIZE_DEF      = 10;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    RUN,
    WAIT_DP,
    DONE,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// WAIT_DP watchdog, present only when LAYER_SEQ_TIMEOUT_EN is defined.
// expired rises combinationally on the LIMIT-th enabled cycle after clear; no flow control.
`ifdef LAYER_SEQ_TIMEOUT_EN
module seq_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = enable && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/layer_sequencer.sv
// Layer sequencer: fetches weights per layer, drives the datapath, chains results; start ignored while busy.
// start at cycle 0 -> final_output_valid at 1+L*(3+D). LAYER_SEQ_TIMEOUT_EN adds a WAIT_DP watchdog.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int  LAYER_MAX      = LAYER_MAX_DEF,
  parameter int  NUM_NEURON     = NUM_NEURON_DEF,
  parameter int  INPUT_SIZE     = INPUT_SIZE_DEF,
  parameter int  WEIGHT_SIZE    = WEIGHT_SIZE_DEF,
  parameter int  ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int LB             = $clog2(LAYER_MAX + 1),
  localparam int ACT_W          = NUM_NEURON * INPUT_SIZE,
  localparam int WGT_W          = NUM_NEURON * NUM_NEURON * WEIGHT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACT_W-1:0]     start_input,
  input  logic [LB-1:0]        num_layers,
  output logic [ADDR_SIZE-1:0] weight_addr,
  output logic                 weight_rd_en,
  input  logic [WGT_W-1:0]     weight_data,
  output logic                 dp_start,
  output logic [ACT_W-1:0]     dp_input,
  output logic [WGT_W-1:0]     dp_weights,
  input  logic [ACT_W-1:0]     dp_output,
  input  logic                 dp_valid,
  output logic [ACT_W-1:0]     final_output,
  output logic                 final_output_valid,
  output logic                 busy,
  output logic [LB-1:0]        layer_idx,
  output logic                 error
);

  seq_state_t       state_q, state_d;
  logic [LB-1:0]    layer_idx_q, layer_cnt_q, eff_layers;
  logic [ACT_W-1:0] dp_input_q, final_q;
  logic [WGT_W-1:0] dp_weights_q;
  logic             error_q, last_layer, wd_expired;

  // A zero request still runs one layer; oversized requests saturate.
  always_comb begin
    eff_layers = num_layers;
    if (num_layers == '0) begin
      eff_layers = LB'(1);
    end else if (int'(num_layers) > LAYER_MAX) begin
      eff_layers = LB'(LAYER_MAX);
    end
  end

  assign last_layer = (layer_idx_q == layer_cnt_q - LB'(1));

`ifdef LAYER_SEQ_TIMEOUT_EN
  seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == RUN),
    .enable ((state_q == WAIT_DP) && !dp_valid),
    .expired(wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    weight_rd_en       = 1'b0;
    dp_start           = 1'b0;
    final_output_valid = 1'b0;
    busy               = 1'b1;
    case (state_q)
      IDLE, ERROR: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        weight_rd_en = 1'b1;
        state_d      = LATCH;
      end
      LATCH: state_d = RUN;
      RUN: begin
        dp_start = 1'b1;
        state_d  = WAIT_DP;
      end
      WAIT_DP: begin
        if (dp_valid) begin
          state_d = last_layer ? DONE : FETCH;
        end else if (wd_expired) begin
          state_d = ERROR;
        end
      end
      DONE: begin
        final_output_valid = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data registers only move in the state that owns them, so stray strobes elsewhere are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_idx_q  <= '0;
      layer_cnt_q  <= '0;
      dp_input_q   <= '0;
      dp_weights_q <= '0;
      final_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (start) begin
            dp_input_q  <= start_input;
            layer_cnt_q <= eff_layers;
            layer_idx_q <= '0;
            error_q     <= 1'b0;
          end
        end
        LATCH: dp_weights_q <= weight_data;
        WAIT_DP: begin
          if (dp_valid) begin
            dp_input_q <= dp_output;
            final_q    <= dp_output;
            if (!last_layer) layer_idx_q <= layer_idx_q + LB'(1);
          end else if (wd_expired) begin
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign weight_addr  = weight_rd_en ? ADDR_SIZE'(layer_idx_q) : '0;
  assign dp_input     = dp_input_q;
  assign dp_weights   = dp_weights_q;
  assign final_output = final_q;
  assign layer_idx    = layer_idx_q;
  assign error        = error_q;

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): LAYER_MAX, 3, maximum layers per pass.
REQ-002 SHALL have parameters: NUM_NEURON, 5, neurons per layer; INPUT_SIZE, 9, activation width; WEIGHT_SIZE, 17, weight width; ADDR_SIZE, 10, weight-memory address width; TIMEOUT_CYCLES, 255, watchdog limit.
REQ-003 SHALL define localparam LB = clog2(LAYER_MAX+1) (2 at defaults).
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports are listed as name, direction, width, meaning.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle pass request.
REQ-008 start_input  input  NUM_NEURON*INPUT_SIZE  first-layer activations.
REQ-009 num_layers  input  LB  layers to run; sampled with start.
REQ-010 weight_addr  output  ADDR_SIZE  layer weight-word address.
REQ-011 weight_rd_en  output  1  weight-memory read strobe.
REQ-012 weight_data  input  NUM_NEURON*NUM_NEURON*WEIGHT_SIZE  read data, valid one cycle after weight_rd_en.
REQ-013 dp_start  output  1  datapath start pulse.
REQ-014 dp_input  output  NUM_NEURON*INPUT_SIZE  datapath activations (registered).
REQ-015 dp_weights  output  NUM_NEURON*NUM_NEURON*WEIGHT_SIZE  datapath weights (registered).
REQ-016 dp_output  input  NUM_NEURON*INPUT_SIZE  datapath result.
REQ-017 dp_valid  input  1  datapath result valid pulse.
REQ-018 final_output  output  NUM_NEURON*INPUT_SIZE  last-layer result (held).
REQ-019 final_output_valid  output  1  one-cycle completion pulse.
REQ-020 busy  output  1  high in every state except IDLE and ERROR.
REQ-021 layer_idx  output  LB  current layer index.
REQ-022 error  output  1  watchdog fault flag.

Function
REQ-023 FSM states SHALL be IDLE, FETCH, LATCH, RUN, WAIT_DP, DONE, ERROR.
REQ-024 IDLE/ERROR + start: latch start_input into dp_input; latch effective layer count; layer_idx=0; error=0; go to FETCH. Otherwise remain in state.
REQ-025 Effective layer count: num_layers==0 -> 1; num_layers>LAYER_MAX -> LAYER_MAX; else num_layers.
REQ-026 start SHALL be ignored while busy.
REQ-027 FETCH: weight_rd_en=1, weight_addr=layer_idx zero-extended; go to LATCH.
REQ-028 LATCH: capture weight_data into dp_weights; go to RUN.
REQ-029 RUN: dp_start=1 for exactly one cycle; go to WAIT_DP.
REQ-030 WAIT_DP + dp_valid: capture dp_output into dp_input and final_output. If layer_idx == count-1, go to DONE; else increment layer_idx and go to FETCH.
REQ-031 dp_valid outside WAIT_DP SHALL be ignored.
REQ-032 DONE: final_output_valid=1 for one cycle; go to IDLE; layer_idx holds.
REQ-033 Latency: with L layers and datapath latency D (dp_start to dp_valid, D>=1), start sampled at cycle 0 gives final_output_valid at cycle 1+L*(3+D).

Reset
REQ-034 rst SHALL override start and every state, including mid-pass.
REQ-035 Next cycle after rst: state IDLE; all outputs 0, including dp_input, dp_weights, final_output, layer_idx and error.

Configuration
REQ-036 With LAYER_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_DP and count each cycle without dp_valid.
REQ-037 When that counter reaches TIMEOUT_CYCLES: go to ERROR and set error=1; error stays high until rst or an accepted start.
REQ-038 Without LAYER_SEQ_TIMEOUT_EN: no counter; error tied 0; ERROR unreachable; WAIT_DP waits indefinitely.

Structure
REQ-039 Package layer_seq_pkg SHALL hold the state enum and default parameter constants shared with the forward datapath.
REQ-040 Timeout counter SHALL be sub-module seq_watchdog (clear, enable, expired), instantiated only under LAYER_SEQ_TIMEOUT_EN.

Verification
REQ-041 Run 3 layers, model D=10: start, num_layers=3 -> three dp_start pulses; weight_addr 0,1,2; final_output_valid at cycle 40; final_output = third dp_output.
REQ-042 Clamping: num_layers=0 -> exactly one dp_start; num_layers=3 with LAYER_MAX=2 -> exactly two.
REQ-043 Busy rejection: start during WAIT_DP with a different start_input -> no effect on dp_input or layer count; one completion only.
REQ-044 Reset mid-pass: rst asserted in WAIT_DP of layer 1 -> next cycle busy=0, layer_idx=0, all outputs 0; late dp_valid ignored.
REQ-045 Timeout (macro on, TIMEOUT_CYCLES=8): dp_valid withheld -> error=1 eight cycles after WAIT_DP entry, busy=0; new start clears error.
REQ-046 Stray dp_valid pulsed in IDLE or FETCH -> no state change; final_output unchanged.
